// File: rtl/sram_read_arbiter.sv
// Two-port, read-only arbiter for the shared 16-bit SRAM: port 0 (audio samples) has priority,
// port 1 (chart data) is forced ahead after STARVE_MAX consecutive port-0 wins while it waits.
module sram_read_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int RD_CYCLES  = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              Clk,
  input  logic              reset,
  // Handshake: req is a level held (with a stable addr) until ack; ack is a one-cycle
  // pulse and rdata is valid from that cycle until the port's next ack.
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        state_dbg,
  output logic [7:0]        starve_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD  = 4'(RD_CYCLES - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [7:0] starve_cnt;
  logic       ctrl_n;
  logic       grant;
  logic       grant_port;
  logic       capture;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_port = req1 && (!req0 || (starve_cnt == STARVE_LIM));
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      // No arbitration here, so a requester still holding req during its ack is not regranted.
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      SRAM_ADDR  <= '0;
      ctrl_n     <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        SRAM_ADDR <= grant_port ? addr1 : addr0;
        owner     <= grant_port;
        ctrl_n    <= 1'b0;
        wait_cnt  <= WAIT_LOAD;
        if (!grant_port && req1)
          starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 8'd1;
        else
          starve_cnt <= '0;
      end
      if (state == ACCESS && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      // Data is sampled on the same edge that releases the controls.
      if (capture) begin
        ctrl_n <= 1'b1;
        if (owner) begin
          rdata1 <= sram_dq_in;
          ack1   <= 1'b1;
        end else begin
          rdata0 <= sram_dq_in;
          ack0   <= 1'b1;
        end
      end
    end
  end

  assign SRAM_CE_N  = ctrl_n;
  assign SRAM_OE_N  = ctrl_n;
  assign SRAM_UB_N  = ctrl_n;
  assign SRAM_LB_N  = ctrl_n;
  assign SRAM_WE_N  = 1'b1;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign starve_dbg = starve_cnt;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: behavioural SRAM, per-port expected queues, ack-time scoring.
module tb_sram_read_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RD = 2;
  localparam int SM = 8;

  logic          Clk;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [DW-1:0] sram_dq_in;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic          busy, owner;
  logic [1:0]    state_dbg;
  logic [7:0]    starve_dbg;

  sram_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD), .STARVE_MAX(SM)
  ) dut (
    .Clk(Clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1),
    .sram_dq_in(sram_dq_in), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .busy(busy), .owner(owner), .state_dbg(state_dbg), .starve_dbg(starve_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 20'h00010)      return 16'hBEEF;
    else if (a == 20'hFFFFF) return 16'h1234;
    else                     return (a[15:0] * 16'd3) ^ 16'h5A3C;
  endfunction

  assign sram_dq_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem_data(SRAM_ADDR) : 16'hDEAD;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp0_q[$];
  logic [AW+DW-1:0] exp1_q[$];
  logic [DW-1:0]    rd0_model, rd1_model;
  int               grant_cyc, low_cnt, ack0_cnt;
  logic             prev_ce_n, prev_ack0, prev_ack1, we_low_seen;

  task automatic score_ack(input bit p, input logic [DW-1:0] got, input logic [DW-1:0] other_got,
                           input logic other_ack, input logic prev);
    logic [AW+DW-1:0] e;
    logic [DW-1:0]    other_model;
    int               depth;
    other_model = p ? rd0_model : rd1_model;
    depth = p ? exp1_q.size() : exp0_q.size();
    if (depth == 0) begin
      check("ack_unexpected", 64'd1, 64'd0);
    end else begin
      if (p) e = exp1_q.pop_front();
      else   e = exp0_q.pop_front();
      check("rdata", got, e[DW-1:0]);
      if (p) rd1_model = e[DW-1:0];
      else   rd0_model = e[DW-1:0];
    end
    check("ack_latency", cyc - grant_cyc, RD);
    check("ctrl_low_cycles", low_cnt, RD);
    check("ctrl_released", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 4'hF);
    check("ack_single_pulse", prev, 1'b0);
    check("other_ack_quiet", other_ack, 1'b0);
    check("other_rdata_held", other_got, other_model);
    check("busy_capture", busy, 1'b1);
    check("owner_at_ack", owner, p);
    low_cnt = 0;
  endtask

  initial begin
    rd0_model = '0; rd1_model = '0;
    grant_cyc = 0; low_cnt = 0; ack0_cnt = 0;
    prev_ce_n = 1'b1; prev_ack0 = 1'b0; prev_ack1 = 1'b0; we_low_seen = 1'b0;
    forever begin
      @(negedge Clk);
      if (reset) begin
        low_cnt = 0; prev_ce_n = 1'b1; prev_ack0 = 1'b0; prev_ack1 = 1'b0;
        rd0_model = '0; rd1_model = '0;
      end else begin
        if (SRAM_WE_N !== 1'b1) we_low_seen = 1'b1;
        if (!SRAM_CE_N) begin
          low_cnt++;
          if (prev_ce_n) begin
            grant_cyc = cyc;
            check("busy_access", busy, 1'b1);
            check("oe_with_ce", {SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);
            if (owner && exp1_q.size() != 0)
              check("sram_addr_p1", SRAM_ADDR, exp1_q[0][AW+DW-1:DW]);
            else if (!owner && exp0_q.size() != 0)
              check("sram_addr_p0", SRAM_ADDR, exp0_q[0][AW+DW-1:DW]);
          end
        end
        if (ack0) begin
          score_ack(1'b0, rdata0, rdata1, ack1, prev_ack0);
          ack0_cnt++;
        end
        if (ack1) score_ack(1'b1, rdata1, rdata0, ack0, prev_ack1);
        prev_ce_n = SRAM_CE_N;
        prev_ack0 = ack0;
        prev_ack1 = ack1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic read0(input logic [AW-1:0] a, input bit keep, output int ack_at);
    exp0_q.push_back({a, mem_data(a)});
    addr0 = a;
    req0  = 1'b1;
    ack_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (ack0) begin
        ack_at = cyc;
        break;
      end
    end
    if (ack_at < 0) check("ack0_timeout", 64'd0, 64'd1);
    if (!keep) req0 = 1'b0;
  endtask

  task automatic read1(input logic [AW-1:0] a, input bit keep, output int ack_at);
    exp1_q.push_back({a, mem_data(a)});
    addr1 = a;
    req1  = 1'b1;
    ack_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (ack1) begin
        ack_at = cyc;
        break;
      end
    end
    if (ack_at < 0) check("ack1_timeout", 64'd0, 64'd1);
    if (!keep) req1 = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int t0, t1, t2, base;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    repeat (3) @(negedge Clk);

    check("rst_ctrl_pins", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    check("rst_sram_addr", SRAM_ADDR, 20'h0);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_rdata0", rdata0, 16'h0);
    check("rst_rdata1", rdata1, 16'h0);
    check("rst_busy_owner", {busy, owner}, 2'b00);
    check("rst_state", state_dbg, 2'd0);
    check("rst_starve", starve_dbg, 8'd0);
    reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Port 0 alone
    read0(20'h00010, 1'b0, t0);
    check("p0_rdata_beef", rdata0, 16'hBEEF);
    repeat (2) @(negedge Clk);

    // Port 1 alone, top of address space
    read1(20'hFFFFF, 1'b0, t1);
    check("p1_rdata_1234", rdata1, 16'h1234);
    check("p1_owner", owner, 1'b1);
    check("p1_sram_addr", SRAM_ADDR, 20'hFFFFF);
    @(negedge Clk);
    check("p1_ack_dropped", ack1, 1'b0);
    repeat (2) @(negedge Clk);

    // Simultaneous requests: port 0 first, port 1 one slot later
    fork
      read0(20'h00100, 1'b0, t0);
      read1(20'h00200, 1'b0, t1);
    join
    check("same_cycle_spacing", t1 - t0, RD + 2);
    repeat (2) @(negedge Clk);

    // Starvation: both held, port 1 forced in after SM port-0 grants
    base = ack0_cnt;
    fork
      begin
        read1(20'h20000, 1'b0, t1);
        check("starve_p0_grants", ack0_cnt - base, SM);
        check("starve_cleared", starve_dbg, 8'd0);
      end
      begin
        for (int i = 0; i < SM + 2; i++) read0(20'h30000 + 20'(i), (i < SM + 1), t0);
      end
    join
    repeat (2) @(negedge Clk);

    // Reset in the first access cycle
    addr0 = 20'h00555;
    req0  = 1'b1;
    @(negedge Clk);
    check("rst_mid_ce_low", SRAM_CE_N, 1'b0);
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge Clk);
    check("rst_mid_ctrl", {SRAM_CE_N, SRAM_OE_N}, 2'b11);
    check("rst_mid_state", state_dbg, 2'd0);
    check("rst_mid_ack", {ack0, ack1}, 2'b00);
    check("rst_mid_rdata", {rdata0, rdata1}, 32'h0);
    check("rst_mid_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      check("rst_mid_no_ack", ack0, 1'b0);
    end
    read0(20'h00010, 1'b0, t0);
    check("post_rst_rdata", rdata0, 16'hBEEF);
    repeat (2) @(negedge Clk);

    // Back-to-back port 0 with a new address on each ack
    read0(20'h00000, 1'b1, t0);
    read0(20'h00001, 1'b1, t1);
    read0(20'h00002, 1'b0, t2);
    check("b2b_spacing_1", t1 - t0, RD + 2);
    check("b2b_spacing_2", t2 - t1, RD + 2);
    repeat (4) @(negedge Clk);

    // Random mix of both ports
    for (int k = 0; k < 6; k++) begin
      fork
        read0(20'($urandom_range(0, 20'hFFFFF)), 1'b0, t0);
        begin
          repeat ($urandom_range(0, 3)) @(negedge Clk);
          read1(20'($urandom_range(0, 20'hFFFFF)), 1'b0, t1);
        end
      join
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    repeat (3) @(negedge Clk);

    check("we_n_never_low", we_low_seen, 1'b0);
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single 16-bit off-chip SRAM read path between two requesters: port 0 is audio sample fetch (high priority) and port 1 is chart/arrow data fetch (low priority).
- Sequences SRAM control pins for fixed-latency reads and samples data from the tristate buffer's read side.
- Returns each word with a one-cycle acknowledge.
- Sits between the sample/chart fetch logic and the SRAM pins at top level; the block is read-only.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
RD_CYCLES, 2, cycles CE_N/OE_N held low with address stable before data is sampled (range 1..15)
STARVE_MAX, 8, consecutive port-0 grants while port 1 is waiting before port 1 is forced ahead (range 1..255)

Ports:
Clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
req0  in  1  port 0 read request, level, held until ack0
addr0  in  ADDR_W  port 0 word address, stable while req0 high
ack0  out  1  one-cycle pulse; rdata0 valid this cycle
rdata0  out  DATA_W  port 0 read data, held until next ack0
req1  in  1  port 1 read request
addr1  in  ADDR_W  port 1 address
ack1  out  1  port 1 acknowledge pulse
rdata1  out  DATA_W  port 1 read data, held
sram_dq_in  in  DATA_W  data from tristate read side
SRAM_ADDR  out  ADDR_W  SRAM address, registered
SRAM_CE_N  out  1  chip enable, active low, registered
SRAM_OE_N  out  1  output enable, active low, registered
SRAM_WE_N  out  1  write enable; constant 1
SRAM_UB_N  out  1  upper byte enable; 0 during access, else 1
SRAM_LB_N  out  1  lower byte enable; 0 during access, else 1
busy  out  1  high in ACCESS and CAPTURE
owner  out  1  port of current or last grant

Behaviour:
- Reset (synchronous, active-high; clock Clk) drives the following:
  - state=IDLE.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N and SRAM_LB_N all 1.
  - SRAM_ADDR=0.
  - ack0=ack1=0, rdata0=rdata1=0.
  - busy=0, owner=0, starve count=0, wait count=0.
- States: IDLE, ACCESS, CAPTURE.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise select a winner:
    - Port 1 wins if req1 is high and (req0 is low or starve count = STARVE_MAX).
    - Else port 0 wins.
  - Register the winner's address into SRAM_ADDR, set owner, drive CE_N/OE_N/UB_N/LB_N to 0, load wait count = RD_CYCLES-1, and go to ACCESS.
  - Starve count update on the grant:
    - Port 0 granted while req1 high: count+1, saturating at STARVE_MAX.
    - Port 1 granted, or req1 low: count cleared to 0.
- ACCESS:
  - Controls held low and address held stable.
  - Decrement wait count each cycle.
  - On the cycle wait count = 0: register sram_dq_in into the owner's rdata register, deassert CE_N/OE_N/UB_N/LB_N (back to 1), and go to CAPTURE.
- CAPTURE:
  - Pulse the owner's ack for exactly one cycle; rdata for that port is already updated.
  - Always return to IDLE. Arbitration never happens in CAPTURE, so a requester still holding req while seeing ack is never regranted.
- Timing:
  - Latency from the IDLE accept edge T: controls low T+1..T+RD_CYCLES, ack at T+RD_CYCLES+1.
  - Per-port throughput is one word per RD_CYCLES+2 cycles.
- Requester protocol:
  - Drop req the cycle after ack, or keep it high for a new read at a new address (addr updated with ack).
  - If req drops mid-access, the access completes and ack still pulses.
  - addr changing mid-access has no effect; the address was latched at grant.
- The non-owner's rdata and ack are never disturbed.
- Reset mid-access: immediate return to IDLE and control deassert on the next edge; no ack issued; rdata cleared.
- SRAM_WE_N is never 0.

Test Plan:
- Port 0 only, RD_CYCLES=2, addr0=0x00010, dq=0xBEEF:
  - CE_N/OE_N low for 2 cycles with SRAM_ADDR=0x00010.
  - ack0 three cycles after the accept edge, rdata0=0xBEEF.
  - ack1 stays 0.
- Port 1 only, addr1=0xFFFFF, dq=0x1234 → SRAM_ADDR=0xFFFFF, ack1 single pulse, rdata1=0x1234, owner=1.
- req0 and req1 rise on the same cycle → port 0 served first, then port 1 on the next IDLE; ack0 precedes ack1 by 4 cycles.
- req0 held high continuously, req1 held high, STARVE_MAX=8 → 8 port-0 grants, 9th grant to port 1, then starve count = 0.
- reset asserted during ACCESS cycle 1 → next edge: CE_N=OE_N=1, state IDLE, no ack, rdata=0; a subsequent request completes normally.
- Back-to-back port 0 with new addr on each ack (0x0, 0x1, 0x2) → acks spaced exactly 4 cycles apart, addresses are correct, SRAM_WE_N stays 1 throughout.
